// File: rtl/uengine_pkg.sv
// uengine_pkg: shared encodings for the engine register sweep.
// Holds the state set, the SPI frame field offsets and the rw codes.
package uengine_pkg;

    typedef enum logic [3:0] {
        IDLE   = 4'd0,
        SCAN   = 4'd1,
        LOAD   = 4'd2,
        START  = 4'd3,
        WAIT   = 4'd4,
        NEXT   = 4'd5,
        DONE   = 4'd6,
        VLOAD  = 4'd7,
        VSTART = 4'd8,
        VWAIT  = 4'd9,
        CHECK  = 4'd10
    } state_t;

    localparam int FRM_RW   = 31;
    localparam int FRM_CHIP = 28;
    localparam int FRM_ENG  = 24;
    localparam int FRM_ADDR = 16;
    localparam int FRM_DATA = 0;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

    function automatic logic [31:0] make_frame(
        input logic        rw,
        input logic [2:0]  chip,
        input logic [3:0]  eng,
        input logic [7:0]  addr,
        input logic [15:0] data
    );
        logic [31:0] f;
        f                  = '0;
        f[FRM_RW]          = rw;
        f[FRM_CHIP +: 3]   = chip;
        f[FRM_ENG +: 4]    = eng;
        f[FRM_ADDR +: 8]   = addr;
        f[FRM_DATA +: 16]  = data;
        return f;
    endfunction

endpackage

// File: rtl/uengine_spi_timer.sv
// uengine_spi_timer: per-frame SPI completion timeout counter.
// Cleared at launch, counts while enabled, flags the last allowed cycle.
module uengine_spi_timer #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [W-1:0] LAST = W'(LIMIT - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (enable && !expired) begin
            cnt <= cnt + W'(1);
        end
    end

    assign expired = (cnt == LAST);

endmodule

// File: rtl/uengine_reg_sweep.sv
// uengine_reg_sweep: writes one register in every present engine, PASS_COUNT times.
// Optional write/read-back verification with retry: UENGINE_SWEEP_READBACK_EN.
module uengine_reg_sweep
    import uengine_pkg::*;
#(
    parameter int ENGINE_COUNT   = 16,
    parameter int PASS_COUNT     = 2,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int MAX_RETRY      = 2
) (
    input  logic        SysClock,
    input  logic        SysResetN,
    input  logic        ModuleStart,
    output logic        ModuleDone,
    output logic        ModuleBusy,
    output logic [31:0] SPI_TX,
    output logic        SPI_START,
    input  logic        SPI_DONE,
    input  logic [31:0] SPI_RX,
    input  logic [15:0] EngineMap,
    input  logic [2:0]  ActualChipIndex,
    input  logic [7:0]  RegAddress,
    input  logic [15:0] RegData,
    input  logic [15:0] PassToggle,
    output logic [7:0]  ErrorCount
);

    localparam logic [4:0] ENG_LAST  = 5'(ENGINE_COUNT - 1);
    localparam logic [1:0] PASS_LAST = 2'(PASS_COUNT - 1);

    state_t      state;
    state_t      state_nx;
    state_t      adv_state;
    logic [4:0]  engine;
    logic [1:0]  pass;
    logic [15:0] wdata;
    logic        map_hit;
    logic        last_eng;
    logic        last_pass;
    logic        accept;
    logic        adv;
    logic        load_w;
    logic        err_inc;
    logic        tmr_clr;
    logic        tmr_en;
    logic        tmr_exp;

    assign wdata     = RegData ^ (pass[0] ? PassToggle : 16'h0000);
    assign map_hit   = (engine <= ENG_LAST) && EngineMap[engine[3:0]];
    assign last_eng  = (engine >= ENG_LAST);
    assign last_pass = (pass == PASS_LAST);
    // The final engine of the final pass goes straight to DONE, no extra wrap cycle.
    assign adv_state = (last_eng && last_pass) ? DONE : SCAN;

    uengine_spi_timer #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timer (
        .clk     (SysClock),
        .rst_n   (SysResetN),
        .clear   (tmr_clr),
        .enable  (tmr_en),
        .expired (tmr_exp)
    );

`ifdef UENGINE_SWEEP_READBACK_EN
    logic       load_r;
    logic       fail;
    logic       retry_inc;
    logic       retry_left;
    logic [3:0] retry;
    logic       unused_rx;

    assign retry_left = ({28'd0, retry} < 32'(MAX_RETRY));
    assign unused_rx  = ^SPI_RX[31:16];

    always_ff @(posedge SysClock or negedge SysResetN) begin
        if (!SysResetN) begin
            retry <= '0;
        end else if (accept || adv) begin
            retry <= '0;
        end else if (retry_inc) begin
            retry <= retry + 4'd1;
        end
    end
`else
    logic unused_rx;
    assign unused_rx = ^{SPI_RX, 32'(MAX_RETRY), RW_READ};
`endif

    always_ff @(posedge SysClock or negedge SysResetN) begin
        if (!SysResetN) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        accept     = 1'b0;
        adv        = 1'b0;
        load_w     = 1'b0;
        err_inc    = 1'b0;
        tmr_clr    = 1'b0;
        tmr_en     = 1'b0;
        ModuleDone = 1'b0;
        ModuleBusy = 1'b1;
        SPI_START  = 1'b0;
`ifdef UENGINE_SWEEP_READBACK_EN
        load_r     = 1'b0;
        fail       = 1'b0;
        retry_inc  = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                ModuleBusy = 1'b0;
                if (ModuleStart) begin
                    accept   = 1'b1;
                    state_nx = SCAN;
                end
            end
            SCAN: begin
                if (map_hit) begin
                    state_nx = LOAD;
                end else begin
                    adv      = 1'b1;
                    state_nx = adv_state;
                end
            end
            LOAD: begin
                load_w   = 1'b1;
                state_nx = START;
            end
            START: begin
                SPI_START = 1'b1;
                tmr_clr   = 1'b1;
                state_nx  = WAIT;
            end
            WAIT: begin
                tmr_en = 1'b1;
`ifdef UENGINE_SWEEP_READBACK_EN
                if (SPI_DONE) begin
                    state_nx = VLOAD;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
`else
                if (SPI_DONE) begin
                    state_nx = NEXT;
                end else if (tmr_exp) begin
                    err_inc  = 1'b1;
                    state_nx = NEXT;
                end
`endif
            end
            NEXT: begin
                adv      = 1'b1;
                state_nx = adv_state;
            end
            DONE: begin
                ModuleDone = 1'b1;
                state_nx   = IDLE;
            end
`ifdef UENGINE_SWEEP_READBACK_EN
            VLOAD: begin
                load_r   = 1'b1;
                state_nx = VSTART;
            end
            VSTART: begin
                SPI_START = 1'b1;
                tmr_clr   = 1'b1;
                state_nx  = VWAIT;
            end
            VWAIT: begin
                tmr_en = 1'b1;
                if (SPI_DONE) begin
                    state_nx = CHECK;
                end else if (tmr_exp) begin
                    fail = 1'b1;
                end
            end
            CHECK: begin
                if (SPI_RX[15:0] == SPI_TX[FRM_DATA +: 16]) begin
                    state_nx = NEXT;
                end else begin
                    fail = 1'b1;
                end
            end
`endif
            default: begin
                ModuleBusy = 1'b0;
                state_nx   = IDLE;
            end
        endcase
`ifdef UENGINE_SWEEP_READBACK_EN
        if (fail) begin
            if (retry_left) begin
                retry_inc = 1'b1;
                state_nx  = LOAD;
            end else begin
                err_inc  = 1'b1;
                state_nx = NEXT;
            end
        end
`endif
    end

    always_ff @(posedge SysClock or negedge SysResetN) begin
        if (!SysResetN) begin
            engine     <= '0;
            pass       <= '0;
            ErrorCount <= '0;
            SPI_TX     <= '0;
        end else begin
            if (accept) begin
                engine     <= '0;
                pass       <= '0;
                ErrorCount <= '0;
            end
            if (adv) begin
                if (last_eng) begin
                    engine <= '0;
                    pass   <= last_pass ? 2'd0 : pass + 2'd1;
                end else begin
                    engine <= engine + 5'd1;
                end
            end
            if (err_inc && (ErrorCount != 8'hFF)) begin
                ErrorCount <= ErrorCount + 8'd1;
            end
            if (load_w) begin
                SPI_TX <= make_frame(RW_WRITE, ActualChipIndex,
                                     engine[3:0], RegAddress, wdata);
`ifdef UENGINE_SWEEP_READBACK_EN
            end else if (load_r) begin
                // Read frame carries the written word so CHECK can compare against it.
                SPI_TX <= make_frame(RW_READ, ActualChipIndex, engine[3:0],
                                     RegAddress, SPI_TX[FRM_DATA +: 16]);
`endif
            end else if (state == DONE) begin
                SPI_TX <= '0;
            end
        end
    end

endmodule

// File: doc/uengine_reg_sweep.md
UENGINE_REG_SWEEP -- requirements
Module: uengine_reg_sweep

Interface
REQ-001 Parameter ENGINE_COUNT, default 16, number of engine slots swept per pass; legal range 1..16.
REQ-002 Parameter PASS_COUNT, default 2, number of full sweeps per start; legal range 1..4.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, maximum SysClock cycles to wait for SPI_DONE per frame.
REQ-004 Parameter MAX_RETRY, default 2, read-back retries per engine; used only when the readback macro is defined.
REQ-005 SysClock  in  1  sole clock; all logic on the rising edge.
REQ-006 SysResetN  in  1  asynchronous, active-low reset.
REQ-007 ModuleStart  in  1  level request to begin a sweep.
REQ-008 ModuleDone  out  1  one-cycle pulse when the sweep completes.
REQ-009 ModuleBusy  out  1  high from the accepted start until the ModuleDone cycle, inclusive.
REQ-010 SPI_TX  out  32  frame = {rw, chip[2:0], engine[3:0], regaddr[7:0], data[15:0]}; rw=0 is write, rw=1 is read.
REQ-011 SPI_START  out  1  one-cycle pulse that launches the SPI transfer.
REQ-012 SPI_DONE  in  1  pulse or level from the SPI engine indicating the transfer is complete.
REQ-013 SPI_RX  in  32  received frame; bits [15:0] carry read data.
REQ-014 EngineMap  in  16  bit e=1 means engine e is present; absent engines are skipped.
REQ-015 ActualChipIndex  in  3  chip address placed in the frame.
REQ-016 RegAddress  in  8  target register address.
REQ-017 RegData  in  16  base data word.
REQ-018 PassToggle  in  16  XOR mask applied to RegData on odd-numbered passes.
REQ-019 ErrorCount  out  8  count of failed engines; saturates at 255.

Function
REQ-020 The block shall use states IDLE, SCAN, LOAD, START, WAIT, NEXT and DONE, plus VLOAD, VSTART, VWAIT and CHECK when the readback macro is defined.
REQ-021 IDLE: the block shall accept a start when ModuleStart=1 and ModuleDone=0, clear the engine and pass counters, clear ErrorCount, and go to SCAN.
REQ-022 SCAN: if engine < ENGINE_COUNT and EngineMap[engine]=1, go to LOAD; if engine < ENGINE_COUNT and the map bit is 0, increment engine with no SPI traffic; otherwise go to NEXT-pass handling.
REQ-023 LOAD: register SPI_TX = {0, ActualChipIndex, engine[3:0], RegAddress, RegData ^ (pass[0] ? PassToggle : 0)}.
REQ-024 START: assert SPI_START for exactly one cycle, clear the timeout counter, and go to WAIT.
REQ-025 WAIT: on SPI_DONE=1 go to NEXT, or to VLOAD when the readback macro is defined; on timeout counter = TIMEOUT_CYCLES-1, increment ErrorCount and go to NEXT.
REQ-026 NEXT: increment engine and return to SCAN; the increment shall be exactly one per accepted engine.
REQ-027 Pass wrap: when engine reaches ENGINE_COUNT, the block shall clear engine and increment pass; when pass reaches PASS_COUNT-1 and wraps, it shall go to DONE.
REQ-028 DONE: assert ModuleDone for one cycle, clear SPI_TX to 0, and return to IDLE; a restart requires ModuleStart still high in a later IDLE cycle.
REQ-029 SPI_TX shall remain stable from LOAD through WAIT, and through VWAIT when the readback macro is defined.
REQ-030 An EngineMap of all zeros shall produce ModuleDone after ENGINE_COUNT*PASS_COUNT+2 cycles with no SPI_START.
REQ-031 Changes to ModuleStart while busy shall be ignored; EngineMap and data inputs shall be sampled live in SCAN and LOAD and held stable by the user during a sweep.
REQ-032 SPI_DONE arriving in the same cycle as SPI_START shall not be accepted; WAIT samples SPI_DONE only from the following cycle.

Reset
REQ-033 SysResetN=0 shall force state IDLE, all counters to 0, SPI_TX=0, SPI_START=0, ModuleDone=0, ModuleBusy=0 and ErrorCount=0, asynchronously and mid-operation included.
REQ-034 After SysResetN deasserts, the block shall not start until the first IDLE cycle that sees ModuleStart=1.

Configuration
REQ-035 Macro UENGINE_SWEEP_READBACK_EN: when defined, each write shall be followed by a read frame (rw=1, same address), and CHECK shall compare SPI_RX[15:0] with the written data.
REQ-036 With the macro defined, a mismatch or timeout shall retry the write and read up to MAX_RETRY times, then increment ErrorCount and advance.
REQ-037 Without the macro, SPI_RX shall be unused and only write frames shall be issued.

Structure
REQ-038 A shared package uengine_pkg shall hold the state encoding, the frame field offsets and the rw constants.
REQ-039 One sub-module, uengine_spi_timer, shall implement the timeout counter (clear, enable, expired).

Verification
REQ-040 EngineMap=16'hFFFF, RegData=16'h0200, PassToggle=16'h0200, PASS_COUNT=2 -> 32 frames; frames 0..15 data 0x0200, frames 16..31 data 0x0000; ModuleDone pulse once.
REQ-041 EngineMap=16'h8001 -> SPI_TX engine fields 0 and 15 only per pass; 4 frames total.
REQ-042 SPI_DONE withheld for engine 3 -> ErrorCount=1 after 1024 cycles; the sweep continues with engine 4.
REQ-043 SysResetN pulsed low during WAIT of engine 5 -> all outputs return to 0 immediately; the next start sweeps from engine 0.
REQ-044 With UENGINE_SWEEP_READBACK_EN, SPI_RX returns 0xFFFF for engine 2 -> 3 write/read pairs for engine 2, ErrorCount=1.
REQ-045 ModuleStart held high continuously -> a new sweep starts one cycle after ModuleDone, never in the ModuleDone cycle.
